text_buffer_ctrl: RTL

Character-buffer stage that sits directly upstream of the VGA text renderer.
- Consumes received bytes from the UART receiver and keeps a COLS x ROWS screen of 7-bit character codes in an internal dual-port RAM.
- Manages a cursor and interprets CR, LF, BS and FF control bytes.
- Serves the renderer: for each pixel coordinate it returns the character code under that pixel, plus the glyph row and column indices, one cycle later.

---
 rtl/text_buffer_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/text_buffer_ctrl.sv
// rtl/text_buffer_ctrl.sv - UART-fed character screen buffer with cursor control and renderer read port
// Keeps a COLS x ROWS grid of 7-bit codes in a dual-port RAM; clears run one cell per cycle.
module text_buffer_ctrl #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int CHAR_W = 8,
  parameter int CHAR_H = 16,
  parameter int ADDR_W = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic [6:0] char_code,
  output logic [3:0] glyph_row,
  output logic [2:0] glyph_col,
  output logic [6:0] cursor_col,
  output logic [4:0] cursor_row,
  output logic       busy
);

  localparam int                CW_SH     = $clog2(CHAR_W);
  localparam int                CH_SH     = $clog2(CHAR_H);
  localparam logic [ADDR_W-1:0] ALL_LAST  = ADDR_W'(COLS*ROWS-1);
  localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(COLS-1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [6:0]        LAST_COL  = 7'(COLS-1);
  localparam logic [4:0]        LAST_ROW  = 5'(ROWS-1);
  localparam logic [10:0]       X_LIM     = 11'(COLS*CHAR_W);
  localparam logic [10:0]       Y_LIM     = 11'(ROWS*CHAR_H);
  localparam logic [6:0]        BLANK     = 7'h20;

  typedef enum logic [1:0] {CLR_ALL, CLR_LINE, IDLE} state_t;

  state_t            r_state, w_nstate;
  logic [ADDR_W-1:0] r_cnt, w_ncnt;
  logic [6:0]        r_col, w_ncol;
  logic [4:0]        r_row, w_nrow;
  logic [4:0]        w_row_inc;
  logic              w_printable;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [6:0]        w_wdata;
  logic [9:0]        w_rd_col, w_rd_row;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_raddr;
  logic [6:0]        r_mem [0:(1<<ADDR_W)-1];
  logic [6:0]        r_char;
  logic [3:0]        r_grow;
  logic [2:0]        r_gcol;

  // Constant-multiplier form; synthesis reduces it to shifts and adds.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ADDR_W-1:0] row,
                                                  input logic [ADDR_W-1:0] col);
    return row * ADDR_W'(COLS) + col;
  endfunction

  assign w_row_inc   = (r_row == LAST_ROW) ? 5'd0 : r_row + 5'd1;
  assign w_printable = (rx_data >= 8'h20) && (rx_data <= 8'h7E);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= CLR_ALL;
      r_cnt   <= '0;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_col   <= w_ncol;
      r_row   <= w_nrow;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_ncol   = r_col;
    w_nrow   = r_row;
    case (r_state)
      CLR_ALL: begin
        if (r_cnt == ALL_LAST) begin
          w_nstate = IDLE;
          w_ncnt   = '0;
        end else begin
          w_ncnt = r_cnt + ONE;
        end
      end
      CLR_LINE: begin
        if (r_cnt == LINE_LAST) begin
          w_nstate = IDLE;
          w_ncnt   = '0;
        end else begin
          w_ncnt = r_cnt + ONE;
        end
      end
      default: begin
        w_ncnt = '0;
        if (rx_valid) begin
          if (w_printable) begin
            if (r_col < LAST_COL) begin
              w_ncol = r_col + 7'd1;
            end else begin
              w_ncol   = '0;
              w_nrow   = w_row_inc;
              w_nstate = CLR_LINE;
            end
          end else begin
            case (rx_data)
              8'h0D: w_ncol = '0;
              8'h0A: begin
                w_nrow   = w_row_inc;
                w_nstate = CLR_LINE;
              end
              8'h08: if (r_col != 7'd0) w_ncol = r_col - 7'd1;
              8'h0C: begin
                w_ncol   = '0;
                w_nrow   = '0;
                w_nstate = CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  always_comb begin
    rx_ready = (r_state == IDLE);
    busy     = (r_state != IDLE);
    w_we     = 1'b0;
    w_waddr  = r_cnt;
    w_wdata  = BLANK;
    case (r_state)
      CLR_ALL: w_we = 1'b1;
      CLR_LINE: begin
        w_we    = 1'b1;
        w_waddr = cell_addr(ADDR_W'(r_row), r_cnt);
      end
      default: begin
        if (rx_valid && w_printable) begin
          w_we    = 1'b1;
          w_waddr = cell_addr(ADDR_W'(r_row), ADDR_W'(r_col));
          w_wdata = rx_data[6:0];
        end else if (rx_valid && rx_data == 8'h08 && r_col != 7'd0) begin
          w_we    = 1'b1;
          w_waddr = cell_addr(ADDR_W'(r_row), ADDR_W'(r_col - 7'd1));
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  assign w_rd_col   = pixel_x >> CW_SH;
  assign w_rd_row   = pixel_y >> CH_SH;
  assign w_in_range = ({1'b0, pixel_x} < X_LIM) && ({1'b0, pixel_y} < Y_LIM);
  assign w_raddr    = cell_addr(ADDR_W'(w_rd_row), ADDR_W'(w_rd_col));

  // Non-blocking read gives old data on a same-address write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_char <= BLANK;
      r_grow <= '0;
      r_gcol <= '0;
    end else begin
      r_char <= w_in_range ? r_mem[w_raddr] : BLANK;
      r_grow <= pixel_y[3:0];
      r_gcol <= pixel_x[2:0];
    end
  end

  assign char_code  = r_char;
  assign glyph_row  = r_grow;
  assign glyph_col  = r_gcol;
  assign cursor_col = r_col;
  assign cursor_row = r_row;

endmodule
